ram_mem_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer that shares one single-port RAM macro between two native memory-bus masters.
- Port 0 is the CPU data bus; port 1 is the AES engine's DMA/key-load port.
- Serialises requests into single-cycle RAM strobes, captures read data and returns a one-cycle ready pulse to the granted master.
- Sits between the masters and the RAM's clk/rst/ce/wstrb/ad/din/dout interface.

---
 rtl/ram_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_ram_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ram_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters; RAM_ARB_BOUNDS_EN adds window checking.
// Latency: valid in IDLE -> ram_ce next cycle -> ready the cycle after; losers hold valid and wait.
module ram_mem_arbiter #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              ram_ce,
  output logic [3:0]        ram_wstrb,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              busy,
  output logic              grant,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              ram_ce_q, ram_ce_d;
  logic [3:0]        ram_wstrb_q, ram_wstrb_d;
  logic [RAM_AW-1:0] ram_ad_q, ram_ad_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              win;
  req_t              win_req;
  logic              in_range;
  logic              unused_bits;

  // On a tie the master that did not win last time goes first.
  assign win     = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
  assign win_req = win ? {m1_addr, m1_wdata, m1_wstrb} : {m0_addr, m0_wdata, m0_wstrb};

`ifdef RAM_ARB_BOUNDS_EN
  assign in_range = (win_req.addr[31:RAM_AW+2] == BASE_ADDR[31:RAM_AW+2]);
`else
  assign in_range = 1'b1;
`endif

  assign unused_bits = ^{win_req.addr[1:0], win_req.addr[31:RAM_AW+2], BASE_ADDR};

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ram_ce_d     = 1'b0;
    ram_wstrb_d  = ram_wstrb_q;
    ram_ad_d     = ram_ad_q;
    ram_din_d    = ram_din_q;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    rd_d         = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d      = win;
          last_grant_d = win;
          if (in_range) begin
            state_d     = ACCESS;
            ram_ce_d    = 1'b1;
            ram_ad_d    = win_req.addr[RAM_AW+1:2];
            ram_din_d   = win_req.wdata;
            ram_wstrb_d = win_req.wstrb;
          end else begin
            // Out-of-window request never touches the RAM.
            state_d    = RESP;
            m0_ready_d = ~win;
            m1_ready_d = win;
            err_d      = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        m0_ready_d  = ~grant_q;
        m1_ready_d  = grant_q;
        rd_d        = (ram_wstrb_q == 4'h0);
        ram_wstrb_d = 4'h0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ram_ce_q     <= 1'b0;
      ram_wstrb_q  <= 4'h0;
      ram_ad_q     <= '0;
      ram_din_q    <= 32'h0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ram_ce_q     <= ram_ce_d;
      ram_wstrb_q  <= ram_wstrb_d;
      ram_ad_q     <= ram_ad_d;
      ram_din_q    <= ram_din_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // RAM read data only arrives in the response cycle, so it is gated rather than re-registered.
  assign m0_rdata  = (m0_ready_q && rd_q) ? ram_dout : 32'h0;
  assign m1_rdata  = (m1_ready_q && rd_q) ? ram_dout : 32'h0;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign ram_ce    = ram_ce_q;
  assign ram_wstrb = ram_wstrb_q;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ram_mem_arbiter.sv
// Directed bench for ram_mem_arbiter with a behavioural single-port RAM.
module tb_ram_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce;
  logic [3:0]  ram_wstrb;
  logic [9:0]  ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        busy, grant, err;

  int n_chk;
  int n_fail;

  ram_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_wstrb(ram_wstrb), .ram_ad(ram_ad), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .grant(grant), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) mem[ram_ad][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_ad];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts and ends at a falling edge with the DUT idle.
  task automatic do_txn(input int idx, input logic p, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [9:0] ead, input logic [31:0] erd);
    if (p) begin
      m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("v%0d_ce", idx), ram_ce, 1);
    chk($sformatf("v%0d_ad", idx), ram_ad, ead);
    chk($sformatf("v%0d_wstrb", idx), ram_wstrb, ws);
    if (ws != 4'h0) chk($sformatf("v%0d_din", idx), ram_din, wd);
    chk($sformatf("v%0d_grant", idx), grant, p);
    chk($sformatf("v%0d_busy", idx), busy, 1);
    chk($sformatf("v%0d_early_rdy", idx), {m0_ready, m1_ready}, 0);
    @(negedge clk);
    chk($sformatf("v%0d_rdy", idx), {m1_ready, m0_ready}, p ? 2 : 1);
    chk($sformatf("v%0d_rdata", idx), p ? m1_rdata : m0_rdata, erd);
    chk($sformatf("v%0d_other_rdata", idx), p ? m0_rdata : m1_rdata, 0);
    chk($sformatf("v%0d_resp_ce", idx), ram_ce, 0);
    chk($sformatf("v%0d_resp_wstrb", idx), ram_wstrb, 0);
    chk($sformatf("v%0d_err", idx), err, 0);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), busy, 0);
  endtask

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [9:0]  exp_ad;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 10'h004, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 10'h004, 32'hA5A5_5A5A};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0000_3C00, 4'h2, 10'h004, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 10'h004, 32'hA5A5_3C5A};
    vecs[4] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 10'h3FF, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0FFF, 32'h0,         4'h0, 10'h3FF, 32'h1234_5678};
    vecs[6] = '{1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 10'h008, 32'h0};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h6, 10'h008, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 10'h008, 32'hDE22_33EF};

    rst = 1'b1;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ce", ram_ce, 0);
    chk("rst_wstrb", ram_wstrb, 0);
    chk("rst_ad", ram_ad, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_ready", {m0_ready, m1_ready}, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_txn(i, vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_ad, vecs[i].exp_rdata);

    // Continuous contention right after reset: 0,1,0,1 every three cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_addr = 32'h10;  m0_wstrb = 4'h0; m0_valid = 1'b1;
    m1_addr = 32'hFFC; m1_wstrb = 4'h0; m1_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_rdy0", i), m0_ready, (i == 2 || i == 8));
      chk($sformatf("cont%0d_rdy1", i), m1_ready, (i == 5 || i == 11));
      chk($sformatf("cont%0d_ce", i), ram_ce, (i % 3 == 1));
      if (i % 3 == 1) chk($sformatf("cont%0d_grant", i), grant, (i == 4 || i == 10));
      if (i == 2 || i == 8) chk($sformatf("cont%0d_rdata0", i), m0_rdata, 32'hA5A5_3C5A);
      if (i == 5 || i == 11) chk($sformatf("cont%0d_rdata1", i), m1_rdata, 32'h1234_5678);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    // Reset while an m1 read is in ACCESS.
    m1_addr = 32'hFFC; m1_wstrb = 4'h0; m1_valid = 1'b1;
    @(negedge clk);
    chk("mid_ce", ram_ce, 1);
    chk("mid_grant", grant, 1);
    rst = 1'b1;
    m1_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_rdy1", m1_ready, 0);
    chk("mid_rdata1", m1_rdata, 0);
    chk("mid_ce_after", ram_ce, 0);
    chk("mid_grant_rst", grant, 0);
    rst = 1'b0;
    m0_addr = 32'h10; m0_wstrb = 4'h0; m0_valid = 1'b1;
    m1_valid = 1'b1;
    @(negedge clk);
    chk("tie_grant", grant, 0);
    chk("tie_ce", ram_ce, 1);
    chk("tie_ad", ram_ad, 10'h004);
    @(negedge clk);
    chk("tie_rdy", {m1_ready, m0_ready}, 2'b01);
    chk("tie_rdata0", m0_rdata, 32'hA5A5_3C5A);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);
    chk("tie_idle", busy, 0);

`ifdef RAM_ARB_BOUNDS_EN
    m0_addr = 32'h0000_1000; m0_wstrb = 4'h0; m0_valid = 1'b1;
    @(negedge clk);
    chk("oob_ce", ram_ce, 0);
    chk("oob_rdy", m0_ready, 1);
    chk("oob_rdata", m0_rdata, 0);
    chk("oob_err", err, 1);
    m0_valid = 1'b0;
    @(negedge clk);
    chk("oob_ce2", ram_ce, 0);
    chk("oob_err_pulse", err, 0);
    chk("oob_rdy_pulse", m0_ready, 0);
    chk("oob_idle", busy, 0);
`else
    do_txn(20, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 10'h000, 32'h0);
    do_txn(21, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 10'h000, 32'hCAFE_F00D);
    do_txn(22, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 10'h000, 32'hCAFE_F00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
